// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared constants for the multicycle MIPS controller:
//   - MIPS opcode constants for the supported instruction subset
//   - 4-bit FSM state encoding (values are visible on state_o)
//   - datapath mux encodings (alu_op, pc_src, alu_src_b)
//   - packed strobe bundle driven by the controller each cycle
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // FSM states; encodings 14/15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_LW  = 4'd6,
    S_MEM_WR = 4'd7,
    S_EXEC_I = 4'd8,
    S_WB_I   = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } mc_state_e;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  // PC source select
  localparam logic [1:0] PC_SEQ    = 2'b00;  // ALU result (PC+4)
  localparam logic [1:0] PC_BRANCH = 2'b01;  // ALUOut (branch target)
  localparam logic [1:0] PC_JUMP   = 2'b10;  // jump address
  localparam logic [1:0] PC_RS     = 2'b11;  // register rs (jr)

  // ALU operand B select
  localparam logic [1:0] SRCB_REG  = 2'b00;  // B register
  localparam logic [1:0] SRCB_FOUR = 2'b01;  // constant 4
  localparam logic [1:0] SRCB_IMM  = 2'b10;  // sign-extended immediate
  localparam logic [1:0] SRCB_IMM2 = 2'b11;  // sign-extended immediate << 2

  // All datapath strobes issued in one cycle
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       ch_31;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } mc_strobes_t;

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the multicycle controller and the shared datapath.
//   datapath -> controller : opcode, funct, zero_flag, mem_ready
//   controller -> datapath : all mux selects / enables, plus debug state,
//                            sticky illegal_op and the two perf counters
// Modports: master = controller side, slave = datapath side.
// Parameter CNT_W sizes cycle_cnt / instr_cnt.
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  // Datapath status
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero_flag;
  logic             mem_ready;
  // Datapath strobes
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             i_or_d;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             reg_dst;
  logic             ch_31;
  logic             mem_to_reg;
  logic             pc_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  // Status / debug
  logic [3:0]       state_o;
  logic             illegal_op;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, funct, zero_flag, mem_ready,
    output pc_write, pc_src, i_or_d, ir_write, mem_read, mem_write,
           reg_dst, ch_31, mem_to_reg, pc_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op,
           state_o, illegal_op, cycle_cnt, instr_cnt
  );

  modport slave (
    output opcode, funct, zero_flag, mem_ready,
    input  pc_write, pc_src, i_or_d, ir_write, mem_read, mem_write,
           reg_dst, ch_31, mem_to_reg, pc_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op,
           state_o, illegal_op, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/mc_perf_counters.sv
// ---------------------------------------------------------------------------
// mc_perf_counters
// Free-running cycle counter and retired-instruction counter for the
// multicycle controller. Both wrap modulo 2^CNT_W.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-low reset (clears both counters)
//   retire    in   one instruction completes this cycle
//   cycle_cnt out  cycles elapsed since reset release
//   instr_cnt out  instructions retired since reset release
// ---------------------------------------------------------------------------
module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  always_comb begin
    cycle_d = cycle_q + 1'b1;
    instr_d = retire ? instr_q + 1'b1 : instr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// FSM sequencing the shared multicycle MIPS datapath (one memory, one ALU,
// IR/MDR/A/B/ALUOut). Supports add/sub/slt/jr, lw, sw, addi, slti, j, jal,
// beq, bne. Strobes are combinational from the current state, with opcode,
// zero_flag and mem_ready folded in where a state depends on them.
//
// Ports:
//   clk   in   single clock, all state on rising edge
//   rst   in   synchronous reset, active low; also masks every strobe
//               combinationally so a reset mid-write drops mem_write at once
//   bus   master modport of multicycle_control_if (status in, strobes out,
//               state_o, sticky illegal_op, cycle_cnt / instr_cnt)
//
// Parameters:
//   CNT_W     width of the performance counters
//   JR_FUNCT  funct code that marks jr inside R-type
//
// Configuration macro: MC_PERF_CNT_EN
//   defined   -> mc_perf_counters instantiated
//   undefined -> cycle_cnt / instr_cnt tied to zero
// ---------------------------------------------------------------------------
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int         CNT_W    = 32,
  parameter logic [5:0] JR_FUNCT = 6'b001000
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  mc_state_e   state_q, state_d;
  logic        illegal_q, illegal_d;
  mc_strobes_t st_raw;  // strobes implied by the current state
  mc_strobes_t st;      // after reset masking

  // -------------------------------------------------------------------------
  // Next state and strobe decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    st_raw    = '0;

    case (state_q)
      S_FETCH: begin
        st_raw.mem_read = 1'b1;
        st_raw.i_or_d   = 1'b0;
        // IR and PC+4 are only committed on the cycle memory delivers
        if (bus.mem_ready) begin
          st_raw.ir_write  = 1'b1;
          st_raw.pc_write  = 1'b1;
          st_raw.pc_src    = PC_SEQ;
          st_raw.alu_src_b = SRCB_FOUR;
          st_raw.alu_op    = ALU_ADD;
          state_d          = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut
        st_raw.alu_src_b = SRCB_IMM2;
        st_raw.alu_op    = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE:      state_d = (bus.funct == JR_FUNCT) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:  state_d = S_ADDR;
          OP_ADDI,
          OP_SLTI:       state_d = S_EXEC_I;
          OP_BEQ,
          OP_BNE:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_JAL:        state_d = S_JAL;
          default: begin
            // Unknown opcode: flag it and refetch without touching state
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        st_raw.alu_src_a = 1'b1;
        st_raw.alu_src_b = SRCB_REG;
        st_raw.alu_op    = ALU_FUNCT;
        state_d          = S_WB_R;
      end

      S_WB_R: begin
        st_raw.reg_dst   = 1'b1;
        st_raw.reg_write = 1'b1;
        state_d          = S_FETCH;
      end

      S_ADDR: begin
        st_raw.alu_src_a = 1'b1;
        st_raw.alu_src_b = SRCB_IMM;
        st_raw.alu_op    = ALU_ADD;
        state_d          = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        st_raw.mem_read = 1'b1;
        st_raw.i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = S_WB_LW;
      end

      S_WB_LW: begin
        st_raw.reg_write  = 1'b1;
        st_raw.mem_to_reg = 1'b1;
        state_d           = S_FETCH;
      end

      S_MEM_WR: begin
        st_raw.mem_write = 1'b1;
        st_raw.i_or_d    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end

      S_EXEC_I: begin
        st_raw.alu_src_a = 1'b1;
        st_raw.alu_src_b = SRCB_IMM;
        st_raw.alu_op    = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d          = S_WB_I;
      end

      S_WB_I: begin
        st_raw.reg_write = 1'b1;
        state_d          = S_FETCH;
      end

      S_BRANCH: begin
        // ALU compares A-B; PC takes ALUOut (target from DECODE) if taken
        st_raw.alu_src_a = 1'b1;
        st_raw.alu_src_b = SRCB_REG;
        st_raw.alu_op    = ALU_SUB;
        st_raw.pc_src    = PC_BRANCH;
        st_raw.pc_write  = ((bus.opcode == OP_BEQ) &&  bus.zero_flag) ||
                           ((bus.opcode == OP_BNE) && !bus.zero_flag);
        state_d          = S_FETCH;
      end

      S_JUMP: begin
        st_raw.pc_write = 1'b1;
        st_raw.pc_src   = PC_JUMP;
        state_d         = S_FETCH;
      end

      S_JAL: begin
        // PC still holds PC+4 this cycle, so r31 gets the return address
        st_raw.pc_write  = 1'b1;
        st_raw.pc_src    = PC_JUMP;
        st_raw.reg_write = 1'b1;
        st_raw.ch_31     = 1'b1;
        st_raw.pc_to_reg = 1'b1;
        state_d          = S_FETCH;
      end

      S_JR: begin
        st_raw.pc_write = 1'b1;
        st_raw.pc_src   = PC_RS;
        state_d         = S_FETCH;
      end

      default: state_d = S_FETCH;  // 14/15: recover silently
    endcase
  end

  // Reset masks strobes combinationally, not just via the state register
  assign st = rst ? st_raw : '0;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.pc_write   = st.pc_write;
  assign bus.pc_src     = st.pc_src;
  assign bus.i_or_d     = st.i_or_d;
  assign bus.ir_write   = st.ir_write;
  assign bus.mem_read   = st.mem_read;
  assign bus.mem_write  = st.mem_write;
  assign bus.reg_dst    = st.reg_dst;
  assign bus.ch_31      = st.ch_31;
  assign bus.mem_to_reg = st.mem_to_reg;
  assign bus.pc_to_reg  = st.pc_to_reg;
  assign bus.reg_write  = st.reg_write;
  assign bus.alu_src_a  = st.alu_src_a;
  assign bus.alu_src_b  = st.alu_src_b;
  assign bus.alu_op     = st.alu_op;
  assign bus.state_o    = state_q;
  assign bus.illegal_op = illegal_q;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef MC_PERF_CNT_EN
  // An instruction retires on the edge that returns a completing state to
  // FETCH. DECODE->FETCH only happens for illegal opcodes and is excluded,
  // as are recoveries from the unused encodings.
  logic retire;

  always_comb begin
    retire = rst && (state_d == S_FETCH) &&
             (state_q inside {S_WB_R, S_WB_LW, S_MEM_WR, S_WB_I,
                              S_BRANCH, S_JUMP, S_JAL, S_JR});
  end

  mc_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .rst       (rst),
    .retire    (retire),
    .cycle_cnt (bus.cycle_cnt),
    .instr_cnt (bus.instr_cnt)
  );
`else
  assign bus.cycle_cnt = {CNT_W{1'b0}};
  assign bus.instr_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control. Each instruction is described by
// its opcode/funct/zero and memory wait counts; a task expands it into the
// per-cycle expectation (state, strobes, sticky flag, counters) from the
// instruction's step sequence and drives the inputs for that cycle. A single
// compare process checks every cycle's outputs on the falling edge. A
// latency monitor measures cycles per instruction from the DUT's state_o,
// checked against hand-computed literals at the end, together with the
// final counter values.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int CW = 32;
`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(CW)) bus ();

  multicycle_control #(
    .CNT_W    (CW),
    .JR_FUNCT (6'b001000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       ch_31;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } sb_t;

  typedef struct {
    logic [3:0]  st;
    sb_t         sb;
    logic        ill;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  sb_t  dut_sb;

  assign dut_sb = {bus.pc_write, bus.pc_src, bus.i_or_d, bus.ir_write,
                   bus.mem_read, bus.mem_write, bus.reg_dst, bus.ch_31,
                   bus.mem_to_reg, bus.pc_to_reg, bus.reg_write,
                   bus.alu_src_a, bus.alu_src_b, bus.alu_op};

  int n_chk = 0;
  int n_fail = 0;
  int ncyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, ncyc, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    ncyc++;
    if (exp_q.size() > 0) begin : cmp
      exp_t e;
      e = exp_q.pop_front();
      chk("strobes",    32'(dut_sb),         32'(e.sb));
      chk("state_o",    32'(bus.state_o),    32'(e.st));
      chk("illegal_op", 32'(bus.illegal_op), 32'(e.ill));
      chk("cycle_cnt",  bus.cycle_cnt,       PERF ? e.cyc : 32'd0);
      chk("instr_cnt",  bus.instr_cnt,       PERF ? e.ins : 32'd0);
    end
  end

  // ---------------- latency monitor (DUT-observed) ----------------
  int         lat_q[$];
  int         lat_cnt = 0;
  logic [3:0] lat_prev = 4'd0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      lat_cnt  = 0;
      lat_prev = 4'd0;
    end else begin
      if (bus.state_o == 4'd0 && lat_prev != 4'd0) begin
        lat_q.push_back(lat_cnt);
        lat_cnt = 0;
      end
      lat_cnt++;
      lat_prev = bus.state_o;
    end
  end

  // ---------------- model + driver ----------------
  logic [5:0]  cur_op = 6'd0;
  logic [5:0]  cur_fn = 6'd0;
  logic        cur_z  = 1'b0;
  logic [31:0] m_cyc  = 32'd0;
  logic [31:0] m_ins  = 32'd0;
  logic        m_ill  = 1'b0;

  // One clock cycle: drive inputs, record what the outputs must be.
  task automatic step(input logic r, input logic mr, input logic [3:0] s,
                      input sb_t sb, input bit ret);
    exp_t e;
    @(posedge clk);
    #2;
    rst           = r;
    bus.mem_ready = mr;
    bus.opcode    = cur_op;
    bus.funct     = cur_fn;
    bus.zero_flag = cur_z;
    e.st  = s;
    e.sb  = r ? sb : '0;   // reset silences every strobe immediately
    e.ill = m_ill;
    e.cyc = m_cyc;
    e.ins = m_ins;
    exp_q.push_back(e);
    if (!r) begin
      m_cyc = 32'd0;
      m_ins = 32'd0;
      m_ill = 1'b0;
    end else begin
      m_cyc++;
      if (ret) m_ins++;
    end
  endtask

  // Expand one instruction into its cycle-by-cycle behaviour.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw, input bit rst_mid);
    sb_t s;
    sb_t dec;
    cur_op = op; cur_fn = fn; cur_z = z;
    s = '0; s.mem_read = 1'b1;
    for (int i = 0; i < fw; i++) step(1'b1, 1'b0, 4'd0, s, 1'b0);
    s.ir_write = 1'b1; s.pc_write = 1'b1; s.alu_src_b = 2'b01;
    step(1'b1, 1'b1, 4'd0, s, 1'b0);
    dec = '0; dec.alu_src_b = 2'b11;
    case (op)
      6'b000000: begin
        step(1'b1, 1'b1, 4'd1, dec, 1'b0);
        if (fn == 6'b001000) begin
          s = '0; s.pc_write = 1'b1; s.pc_src = 2'b11;
          step(1'b1, 1'b1, 4'd13, s, 1'b1);
        end else begin
          s = '0; s.alu_src_a = 1'b1; s.alu_op = 2'b10;
          step(1'b1, 1'b1, 4'd2, s, 1'b0);
          s = '0; s.reg_dst = 1'b1; s.reg_write = 1'b1;
          step(1'b1, 1'b1, 4'd3, s, 1'b1);
        end
      end
      6'b100011, 6'b101011: begin
        step(1'b1, 1'b1, 4'd1, dec, 1'b0);
        s = '0; s.alu_src_a = 1'b1; s.alu_src_b = 2'b10;
        step(1'b1, 1'b1, 4'd4, s, 1'b0);
        if (op == 6'b100011) begin
          s = '0; s.mem_read = 1'b1; s.i_or_d = 1'b1;
          for (int i = 0; i < mw; i++) step(1'b1, 1'b0, 4'd5, s, 1'b0);
          step(1'b1, 1'b1, 4'd5, s, 1'b0);
          s = '0; s.reg_write = 1'b1; s.mem_to_reg = 1'b1;
          step(1'b1, 1'b1, 4'd6, s, 1'b1);
        end else begin
          s = '0; s.mem_write = 1'b1; s.i_or_d = 1'b1;
          for (int i = 0; i < mw; i++) step(1'b1, 1'b0, 4'd7, s, 1'b0);
          if (rst_mid) step(1'b0, 1'b0, 4'd7, s, 1'b0);
          else         step(1'b1, 1'b1, 4'd7, s, 1'b1);
        end
      end
      6'b001000, 6'b001010: begin
        step(1'b1, 1'b1, 4'd1, dec, 1'b0);
        s = '0; s.alu_src_a = 1'b1; s.alu_src_b = 2'b10;
        s.alu_op = (op == 6'b001010) ? 2'b11 : 2'b00;
        step(1'b1, 1'b1, 4'd8, s, 1'b0);
        s = '0; s.reg_write = 1'b1;
        step(1'b1, 1'b1, 4'd9, s, 1'b1);
      end
      6'b000100, 6'b000101: begin
        step(1'b1, 1'b1, 4'd1, dec, 1'b0);
        s = '0; s.alu_src_a = 1'b1; s.alu_op = 2'b01; s.pc_src = 2'b01;
        s.pc_write = (op == 6'b000100) ? z : !z;
        step(1'b1, 1'b1, 4'd10, s, 1'b1);
      end
      6'b000010: begin
        step(1'b1, 1'b1, 4'd1, dec, 1'b0);
        s = '0; s.pc_write = 1'b1; s.pc_src = 2'b10;
        step(1'b1, 1'b1, 4'd11, s, 1'b1);
      end
      6'b000011: begin
        step(1'b1, 1'b1, 4'd1, dec, 1'b0);
        s = '0; s.pc_write = 1'b1; s.pc_src = 2'b10;
        s.reg_write = 1'b1; s.ch_31 = 1'b1; s.pc_to_reg = 1'b1;
        step(1'b1, 1'b1, 4'd12, s, 1'b1);
      end
      default: begin
        step(1'b1, 1'b1, 4'd1, dec, 1'b0);
        m_ill = 1'b1;  // visible from the cycle after DECODE
      end
    endcase
  endtask

  // Cycles per instruction as seen on state_o, derived by hand from the
  // step counts (+1 per wait cycle).
  int exp_lat [22] = '{4, 7, 3, 3, 3, 3, 3, 4, 5, 4, 3, 2,
                       4, 4, 4, 4, 4, 4, 4, 4, 4, 4};

  initial begin : main
    sb_t idle;
    rst           = 1'b0;
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    bus.zero_flag = 1'b0;
    bus.mem_ready = 1'b0;

    step(1'b0, 1'b0, 4'd0, '0, 1'b0);
    step(1'b0, 1'b0, 4'd0, '0, 1'b0);

    instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);  // add
    instr(6'b100011, 6'b000000, 1'b0, 0, 2, 1'b0);  // lw, 2 wait cycles
    instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);  // beq taken
    instr(6'b000101, 6'b000000, 1'b1, 0, 0, 1'b0);  // bne not taken
    instr(6'b000101, 6'b000000, 1'b0, 0, 0, 1'b0);  // bne taken
    instr(6'b000011, 6'b000000, 1'b0, 0, 0, 1'b0);  // jal
    instr(6'b000000, 6'b001000, 1'b0, 0, 0, 1'b0);  // jr
    instr(6'b001000, 6'b001000, 1'b0, 0, 0, 1'b0);  // addi
    instr(6'b001010, 6'b000000, 1'b1, 1, 0, 1'b0);  // slti, 1 fetch wait
    instr(6'b101011, 6'b000000, 1'b0, 0, 0, 1'b0);  // sw
    instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0);  // j
    instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);  // illegal
    instr(6'b101011, 6'b000000, 1'b0, 0, 1, 1'b1);  // sw, reset in MEM_WR
    for (int k = 0; k < 10; k++)
      instr(6'b001000, 6'b000000, 1'b0, 0, 0, 1'b0);  // 10 addi

    idle = '0; idle.mem_read = 1'b1;
    step(1'b1, 1'b0, 4'd0, idle, 1'b0);
    @(negedge clk);
    #1;
    chk("final_cycle_cnt", bus.cycle_cnt,  PERF ? 32'd40 : 32'd0);
    chk("final_instr_cnt", bus.instr_cnt,  PERF ? 32'd10 : 32'd0);
    chk("final_illegal",   32'(bus.illegal_op), 32'd0);
    chk("final_state",     32'(bus.state_o),    32'd0);
    chk("latency_count",   32'(lat_q.size()),   32'd22);
    for (int i = 0; i < 22 && i < lat_q.size(); i++)
      chk($sformatf("latency[%0d]", i), 32'(lat_q[i]), 32'(exp_lat[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
